// File: rtl/fizzbuzz_sequencer.sv
// ---------------------------------------------------------------------------
// fizzbuzz_sequencer
//   Walks n = 1..MAX_N and streams each FizzBuzz line as 7-bit ASCII, one
//   character per send strobe, to a serial transmitter. Every line ends in
//   CR LF. The number is kept in BCD and divisibility is tracked with
//   wrapping mod-3 / mod-5 counters, so no dividers are needed.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   start_i   one-cycle run request, honoured only when idle or done
//   busy_i    serial transmitter busy; a character is handed off only when low
//   char_o    ASCII character, valid while send_o is high
//   send_o    one-cycle strobe handing char_o to the transmitter
//   active_o  high from start acceptance until the last LF is handed off
//   done_o    high after the final line until the next start or reset
// ---------------------------------------------------------------------------
module fizzbuzz_sequencer #(
    parameter int MAX_N  = 100,
    parameter int DIGITS = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       busy_i,
    output logic [6:0] char_o,
    output logic       send_o,
    output logic       active_o,
    output logic       done_o
);

    localparam int NW = 4 * DIGITS;
    // Index/length width: longest line is "FizzBuzz" CR LF (10) or DIGITS+2.
    localparam int IW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EMIT, S_GUARD, S_DRAIN, S_NEXT, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        L_NUM, L_FIZZ, L_BUZZ, L_FB
    } line_e;

    // Constant-only conversion of the last number to BCD for the end test.
    function automatic logic [NW-1:0] to_bcd(input int value);
        logic [NW-1:0] bcd;
        int            v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[i*4 +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return bcd;
    endfunction

    // Number of significant BCD digits (n is never zero, so at least one).
    function automatic logic [IW-1:0] sig_digits(input logic [NW-1:0] bcd);
        logic [IW-1:0] cnt;
        cnt = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                cnt = IW'(i + 1);
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Text glyphs; "FizzBuzz" is "Fizz" for idx 0..3 and "Buzz" for 4..7.
    function automatic logic [6:0] text_glyph(input line_e kind, input logic [2:0] idx);
        logic       buzz_half;
        logic [6:0] g;
        buzz_half = (kind == L_BUZZ) || ((kind == L_FB) && idx[2]);
        case (idx[1:0])
            2'd0:    g = buzz_half ? 7'h42 : 7'h46;  // 'B' / 'F'
            2'd1:    g = buzz_half ? 7'h75 : 7'h69;  // 'u' / 'i'
            default: g = 7'h7A;                      // 'z'
        endcase
        return g;
    endfunction

    localparam logic [NW-1:0] MAX_BCD = to_bcd(MAX_N);
    localparam logic [NW-1:0] BCD_ONE = NW'(1);

    state_e        state_q;
    line_e         kind_q;
    logic [NW-1:0] n_q;
    logic [NW-1:0] n_d;
    logic [1:0]    mod3_q;
    logic [1:0]    mod3_d;
    logic [2:0]    mod5_q;
    logic [2:0]    mod5_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] len_q;
    logic [6:0]    char_q;
    logic [6:0]    char_d;
    logic          send_q;
    logic          active_q;
    logic          done_q;

    logic          carry_s;
    logic [IW-1:0] digit_pos_s;
    logic [3:0]    digit_s;

    // BCD increment with ripple carry across digits, and wrapping mod counters.
    always_comb begin
        n_d     = n_q;
        carry_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (n_q[i*4 +: 4] == 4'd9) begin
                    n_d[i*4 +: 4] = 4'd0;
                    carry_s       = 1'b1;
                end else begin
                    n_d[i*4 +: 4] = n_q[i*4 +: 4] + 4'd1;
                    carry_s       = 1'b0;
                end
            end else begin
                n_d[i*4 +: 4] = n_q[i*4 +: 4];
            end
        end
        mod3_d = (mod3_q == 2'd2) ? 2'd0 : (mod3_q + 2'd1);
        mod5_d = (mod5_q == 3'd4) ? 3'd0 : (mod5_q + 3'd1);
    end

    // Glyph for the current index: body characters, then CR, then LF.
    // Digits go out most significant first, so idx 0 maps to position len-3.
    always_comb begin
        digit_pos_s = len_q - 4'd3 - idx_q;
        digit_s     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == digit_pos_s) begin
                digit_s = n_q[i*4 +: 4];
            end else begin
                digit_s = digit_s;
            end
        end
        if (idx_q == (len_q - 4'd2)) begin
            char_d = 7'h0D;
        end else if (idx_q == (len_q - 4'd1)) begin
            char_d = 7'h0A;
        end else if (kind_q == L_NUM) begin
            char_d = 7'h30 + {3'b000, digit_s};
        end else begin
            char_d = text_glyph(kind_q, idx_q[2:0]);
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            kind_q   <= L_NUM;
            n_q      <= BCD_ONE;
            mod3_q   <= 2'd1;
            mod5_q   <= 3'd1;
            idx_q    <= 4'd0;
            len_q    <= 4'd0;
            char_q   <= 7'h00;
            send_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            send_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        done_q   <= 1'b0;
                        active_q <= 1'b1;
                        n_q      <= BCD_ONE;
                        mod3_q   <= 2'd1;
                        mod5_q   <= 3'd1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    idx_q   <= 4'd0;
                    state_q <= S_EMIT;
                    if ((mod3_q == 2'd0) && (mod5_q == 3'd0)) begin
                        kind_q <= L_FB;
                        len_q  <= 4'd10;
                    end else if (mod3_q == 2'd0) begin
                        kind_q <= L_FIZZ;
                        len_q  <= 4'd6;
                    end else if (mod5_q == 3'd0) begin
                        kind_q <= L_BUZZ;
                        len_q  <= 4'd6;
                    end else begin
                        kind_q <= L_NUM;
                        len_q  <= sig_digits(n_q) + 4'd2;
                    end
                end
                S_EMIT: begin
                    if (!busy_i) begin
                        send_q  <= 1'b1;
                        char_q  <= char_d;
                        state_q <= S_GUARD;
                    end
                end
                // The transmitter may not have raised busy yet; skip one cycle.
                S_GUARD: begin
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!busy_i) begin
                        if (idx_q == (len_q - 4'd1)) begin
                            state_q <= S_NEXT;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= S_EMIT;
                        end
                    end
                end
                S_NEXT: begin
                    if (n_q == MAX_BCD) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        n_q     <= n_d;
                        mod3_q  <= mod3_d;
                        mod5_q  <= mod5_d;
                        state_q <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign char_o   = char_q;
    assign send_o   = send_q;
    assign active_o = active_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fizzbuzz_sequencer
//   Two sequencers (MAX_N=100 and MAX_N=15), each with a simple serial model
//   that holds busy for a programmable number of cycles per character and can
//   add random busy glitches. Expected characters are pushed to a queue when
//   a run is started and popped as the DUT strobes send.
// ---------------------------------------------------------------------------
module tb_fizzbuzz_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s    [2];
    logic       start_s  [2];
    logic       busy_s   [2];
    logic [6:0] char_s   [2];
    logic       send_s   [2];
    logic       active_s [2];
    logic       done_s   [2];

    int  busy_len  [2];
    int  busy_cnt  [2];
    bit  glitch_en [2];
    int  send_cnt  [2];
    logic done_prev   [2];
    logic active_prev [2];

    logic [6:0] exp_a [$];
    logic [6:0] exp_b [$];

    int n_vec  = 0;
    int n_miss = 0;

    fizzbuzz_sequencer #(.MAX_N(100), .DIGITS(3)) dut_a (
        .clk_i(clk), .rst_i(rst_s[0]), .start_i(start_s[0]), .busy_i(busy_s[0]),
        .char_o(char_s[0]), .send_o(send_s[0]), .active_o(active_s[0]), .done_o(done_s[0])
    );

    fizzbuzz_sequencer #(.MAX_N(15), .DIGITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst_s[1]), .start_i(start_s[1]), .busy_i(busy_s[1]),
        .char_o(char_s[1]), .send_o(send_s[1]), .active_o(active_s[1]), .done_o(done_s[1])
    );

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_char(input int k, input logic [6:0] c);
        if (k == 0) exp_a.push_back(c);
        else        exp_b.push_back(c);
    endtask

    // Reference model: the whole run as ASCII, built with ordinary arithmetic.
    task automatic push_run(input int k, input int maxn);
        string s;
        byte   b;
        for (int n = 1; n <= maxn; n++) begin
            if (n % 15 == 0)     s = "FizzBuzz";
            else if (n % 3 == 0) s = "Fizz";
            else if (n % 5 == 0) s = "Buzz";
            else                 s = $sformatf("%0d", n);
            for (int i = 0; i < s.len(); i++) begin
                b = s[i];
                push_char(k, b[6:0]);
            end
            push_char(k, 7'h0D);
            push_char(k, 7'h0A);
        end
    endtask

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Serial model, scoreboard pop and done/active edge checks.
    always @(negedge clk) begin
        logic [6:0] e;
        for (int k = 0; k < 2; k++) begin
            if (send_s[k] === 1'b1) begin
                chk("no_send_while_busy", {31'd0, busy_s[k]}, 32'd0);
                send_cnt[k]++;
                if (exp_size(k) == 0) begin
                    chk("unexpected_send", 32'd1, 32'd0);
                end else begin
                    if (k == 0) e = exp_a.pop_front();
                    else        e = exp_b.pop_front();
                    chk(k == 0 ? "char_n100" : "char_n15", {25'd0, char_s[k]}, {25'd0, e});
                end
                busy_cnt[k] = busy_len[k];
            end else if (busy_cnt[k] > 0) begin
                busy_cnt[k]--;
            end
            busy_s[k] = (busy_cnt[k] > 0) || (glitch_en[k] && ($urandom_range(0, 3) == 0));
            if (done_s[k] === 1'b1 && done_prev[k] === 1'b0) begin
                chk("active_falls_with_done", {30'd0, active_prev[k], active_s[k]}, 32'd2);
                chk("done_after_last_char", exp_size(k), 32'd0);
            end
            done_prev[k]   = done_s[k];
            active_prev[k] = active_s[k];
        end
    end

    // Pulse start; edge 0 is the sampling edge. Optionally check send latency.
    task automatic start_run(input int k, input bit chk_lat);
        @(negedge clk);
        start_s[k] = 1'b1;
        @(posedge clk);
        #1 start_s[k] = 1'b0;
        chk("active_after_start", {31'd0, active_s[k]}, 32'd1);
        chk("done_clear_after_start", {31'd0, done_s[k]}, 32'd0);
        if (chk_lat) begin
            @(negedge clk);
            chk("no_send_after_edge0", {31'd0, send_s[k]}, 32'd0);
            @(negedge clk);
            chk("no_send_after_edge1", {31'd0, send_s[k]}, 32'd0);
            @(negedge clk);
            chk("send_after_edge2", {31'd0, send_s[k]}, 32'd1);
        end
    endtask

    task automatic wait_sends(input int k, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (send_cnt[k] >= n) break;
        end
        chk("send_count_timeout", {31'd0, send_cnt[k] >= n}, 32'd1);
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_s[k] === 1'b1) break;
        end
        chk("done_timeout", {31'd0, done_s[k]}, 32'd1);
        chk("active_low_at_end", {31'd0, active_s[k]}, 32'd0);
        chk("queue_empty_at_end", exp_size(k), 32'd0);
    endtask

    initial begin
        int total;
        for (int k = 0; k < 2; k++) begin
            rst_s[k]     = 1'b1;
            start_s[k]   = 1'b0;
            busy_s[k]    = 1'b0;
            busy_len[k]  = 0;
            busy_cnt[k]  = 0;
            glitch_en[k] = 1'b0;
            send_cnt[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_send",   {31'd0, send_s[k]},   32'd0);
            chk("reset_char",   {25'd0, char_s[k]},   32'd0);
            chk("reset_active", {31'd0, active_s[k]}, 32'd0);
            chk("reset_done",   {31'd0, done_s[k]},   32'd0);
        end
        @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Reset while draining the first character of line 3.
        busy_len[0] = 20;
        push_run(0, 100);
        start_run(0, 1'b0);
        wait_sends(0, 7, 2000);
        repeat (5) @(posedge clk);
        #2 rst_s[0] = 1'b1;
        #1;
        chk("midrun_rst_send",   {31'd0, send_s[0]},   32'd0);
        chk("midrun_rst_char",   {25'd0, char_s[0]},   32'd0);
        chk("midrun_rst_active", {31'd0, active_s[0]}, 32'd0);
        chk("midrun_rst_done",   {31'd0, done_s[0]},   32'd0);
        exp_a.delete();
        busy_cnt[0] = 0;
        @(negedge clk);
        rst_s[0] = 1'b0;

        // Full MAX_N=100 run with busy low, latency check, start while active.
        busy_len[0] = 0;
        send_cnt[0] = 0;
        push_run(0, 100);
        total = exp_a.size();
        start_run(0, 1'b1);
        wait_sends(0, 20, 500);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("start_ignored_active", {31'd0, active_s[0]}, 32'd1);
        wait_done(0, 6000);
        chk("sends_n100", send_cnt[0], total);

        // Restart from DONE with a slow, glitchy transmitter.
        repeat (4) @(posedge clk);
        chk("done_held", {31'd0, done_s[0]}, 32'd1);
        glitch_en[0] = 1'b1;
        busy_len[0]  = 2;
        send_cnt[0]  = 0;
        push_run(0, 100);
        total = exp_a.size();
        start_run(0, 1'b0);
        wait_done(0, 15000);
        chk("sends_n100_glitch", send_cnt[0], total);

        // MAX_N=15 with a 500-cycle busy per character.
        busy_len[1] = 500;
        send_cnt[1] = 0;
        push_run(1, 15);
        start_run(1, 1'b0);
        wait_done(1, 45000);
        chk("sends_n15", send_cnt[1], 32'd73);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
